// File: rtl/perm_pkg.sv
// Shared layout constants and types for the 200-bit chunked Keccak state interface.
package perm_pkg;

  localparam int unsigned LANE_W  = 64;
  localparam int unsigned BEAT_W  = 200;
  localparam int unsigned NBEATS  = 8;
  localparam int unsigned STATE_W = BEAT_W * NBEATS;
  localparam int unsigned IX_W    = $clog2(NBEATS);

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

  // Bit offset of lane (x,y) inside a packed 1600-bit state.
  function automatic int unsigned lane_lsb(input int unsigned x, input int unsigned y);
    return LANE_W * (5 * y + x);
  endfunction

endpackage

// File: rtl/state_serializer.sv
// Streams a 1600-bit state as eight indexed 200-bit beats, with a one-deep
// pending buffer so the next state follows the current one without a bubble.
module state_serializer #(
  parameter  int unsigned BEAT_W  = perm_pkg::BEAT_W,
  parameter  int unsigned NBEATS  = perm_pkg::NBEATS,
  parameter  int unsigned IX_W    = perm_pkg::IX_W,
  localparam int unsigned STATE_W = BEAT_W * NBEATS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pushin,
  input  logic [STATE_W-1:0] din,
  output logic               ready,
  output logic               pushout,
  output logic [IX_W-1:0]    doutix,
  output logic [BEAT_W-1:0]  dout,
  output logic               overflow
);
  import perm_pkg::*;

  localparam logic [IX_W-1:0] LAST_IX = IX_W'(NBEATS - 1);

  ser_state_t         state_q, state_d;
  logic [STATE_W-1:0] a_q, a_d;
  logic [STATE_W-1:0] p_q, p_d;
  logic               pend_valid_q, pend_valid_d;
  logic [IX_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]  dout_q, dout_d;
  logic [IX_W-1:0]    doutix_q, doutix_d;
  logic               pushout_q, pushout_d;
  logic               overflow_q, overflow_d;

  assign ready    = !pend_valid_q;
  assign pushout  = pushout_q;
  assign doutix   = doutix_q;
  assign dout     = dout_q;
  assign overflow = overflow_q;

  // Next-state, buffer management and registered beat outputs.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    p_d          = p_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    dout_d       = '0;
    doutix_d     = '0;
    pushout_d    = 1'b0;
    // A push while the pending slot is full is dropped and flagged forever.
    overflow_d   = overflow_q | (pushin & pend_valid_q);

    case (state_q)
      SER_IDLE: begin
        if (pushin) begin
          dout_d    = din[BEAT_W-1:0];
          doutix_d  = '0;
          pushout_d = 1'b1;
          a_d       = din;
          cnt_d     = IX_W'(1);
          state_d   = SER_SEND;
        end
      end
      SER_SEND: begin
        dout_d    = a_q[BEAT_W*cnt_q +: BEAT_W];
        doutix_d  = cnt_q;
        pushout_d = 1'b1;
        cnt_d     = cnt_q + IX_W'(1);
        if (cnt_q != LAST_IX) begin
          if (pushin && !pend_valid_q) begin
            p_d          = din;
            pend_valid_d = 1'b1;
          end
        end else begin
          // Last beat leaves this edge; reload A so beat 0 of the next state follows directly.
          if (pend_valid_q) begin
            a_d          = p_q;
            pend_valid_d = 1'b0;
          end else if (pushin) begin
            a_d = din;
          end else begin
            state_d = SER_IDLE;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  // State and data registers, cleared asynchronously by active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SER_IDLE;
      a_q          <= '0;
      p_q          <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      dout_q       <= '0;
      doutix_q     <= '0;
      pushout_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      p_q          <= p_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      doutix_q     <= doutix_d;
      pushout_q    <= pushout_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_state_serializer.sv
// Directed and randomized checks for state_serializer.
module tb_state_serializer;
  import perm_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               pushin = 1'b0;
  logic [STATE_W-1:0] din = '0;
  logic               ready;
  logic               pushout;
  logic [IX_W-1:0]    doutix;
  logic [BEAT_W-1:0]  dout;
  logic               overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  state_serializer #(
    .BEAT_W(BEAT_W),
    .NBEATS(NBEATS),
    .IX_W  (IX_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pushin  (pushin),
    .din     (din),
    .ready   (ready),
    .pushout (pushout),
    .doutix  (doutix),
    .dout    (dout),
    .overflow(overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [STATE_W-1:0] pattern_state(input logic [7:0] salt);
    logic [STATE_W-1:0] s;
    s = '0;
    for (int unsigned y = 0; y < 5; y++)
      for (int unsigned x = 0; x < 5; x++)
        s[lane_lsb(x, y) +: 64] = {8{4'(x), 4'(y)}} ^ {8{salt}};
    return s;
  endfunction

  function automatic logic [STATE_W-1:0] rand_state();
    logic [STATE_W-1:0] s;
    for (int unsigned i = 0; i < STATE_W / 32; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [BEAT_W-1:0] beat_of(input logic [STATE_W-1:0] s, input int unsigned k);
    return s[k*BEAT_W +: BEAT_W];
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    pushin = 1'b0;
    #12;
    n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL reset_pushout: got %b required 0", pushout); end
    n_checks++; if (doutix !== '0) begin n_fail++; $display("FAIL reset_doutix: got %0d required 0", doutix); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h required 0", dout); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    @(negedge clk);
    reset = 1'b1;
    step();
    n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL idle_pushout: got %b required 0", pushout); end
  endtask

  task automatic test_single();
    logic [STATE_W-1:0] s;
    s = pattern_state(8'h00);
    din = s;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    for (int unsigned k = 0; k < NBEATS; k++) begin
      n_checks++; if (pushout !== 1'b1) begin n_fail++; $display("FAIL single_pushout[%0d]: got %b required 1", k, pushout); end
      n_checks++; if (doutix !== IX_W'(k)) begin n_fail++; $display("FAIL single_doutix[%0d]: got %0d required %0d", k, doutix, k); end
      n_checks++; if (dout !== beat_of(s, k)) begin n_fail++; $display("FAIL single_dout[%0d]: got %h required %h", k, dout, beat_of(s, k)); end
      step();
    end
    n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL single_end_pushout: got %b required 0", pushout); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL single_end_dout: got %h required 0", dout); end
    n_checks++; if (doutix !== '0) begin n_fail++; $display("FAIL single_end_doutix: got %0d required 0", doutix); end
  endtask

  // Second state pushed while beat 3 of the first is on the output.
  task automatic test_back_to_back();
    logic [STATE_W-1:0] s1, s2;
    int unsigned ready_low;
    s1 = pattern_state(8'h11);
    s2 = pattern_state(8'hA5);
    ready_low = 0;
    din = s1;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    for (int unsigned i = 0; i < 2*NBEATS; i++) begin
      n_checks++; if (pushout !== 1'b1) begin n_fail++; $display("FAIL b2b_pushout[%0d]: got %b required 1", i, pushout); end
      n_checks++; if (doutix !== IX_W'(i % NBEATS)) begin n_fail++; $display("FAIL b2b_doutix[%0d]: got %0d required %0d", i, doutix, i % NBEATS); end
      n_checks++; if (dout !== beat_of(i < NBEATS ? s1 : s2, i % NBEATS)) begin
        n_fail++; $display("FAIL b2b_dout[%0d]: got %h required %h", i, dout, beat_of(i < NBEATS ? s1 : s2, i % NBEATS));
      end
      if (!ready) ready_low++;
      if (i == 3) begin din = s2; pushin = 1'b1; end else pushin = 1'b0;
      step();
    end
    pushin = 1'b0;
    // P loads at the edge after beat 3, promoted at the edge driving beat 7: low during beats 4..6.
    n_checks++; if (ready_low !== 3) begin n_fail++; $display("FAIL b2b_ready_low: got %0d cycles required 3", ready_low); end
    n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL b2b_end_pushout: got %b required 0", pushout); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b required 0", overflow); end
  endtask

  // Second state sampled on the edge that drives beat 7: goes straight into A.
  task automatic test_direct_reload();
    logic [STATE_W-1:0] s1, s2;
    int unsigned ready_high;
    s1 = pattern_state(8'h3C);
    s2 = pattern_state(8'hC3);
    ready_high = 0;
    din = s1;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    for (int unsigned i = 0; i < 2*NBEATS; i++) begin
      n_checks++; if (pushout !== 1'b1) begin n_fail++; $display("FAIL direct_pushout[%0d]: got %b required 1", i, pushout); end
      n_checks++; if (doutix !== IX_W'(i % NBEATS)) begin n_fail++; $display("FAIL direct_doutix[%0d]: got %0d required %0d", i, doutix, i % NBEATS); end
      n_checks++; if (dout !== beat_of(i < NBEATS ? s1 : s2, i % NBEATS)) begin
        n_fail++; $display("FAIL direct_dout[%0d]: got %h required %h", i, dout, beat_of(i < NBEATS ? s1 : s2, i % NBEATS));
      end
      if (ready) ready_high++;
      if (i == 6) begin din = s2; pushin = 1'b1; end else pushin = 1'b0;
      step();
    end
    pushin = 1'b0;
    n_checks++; if (ready_high !== 2*NBEATS) begin n_fail++; $display("FAIL direct_ready_high: got %0d cycles required %0d", ready_high, 2*NBEATS); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL direct_overflow: got %b required 0", overflow); end
    n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL direct_end_pushout: got %b required 0", pushout); end
  endtask

  task automatic test_overflow();
    logic [STATE_W-1:0] s1, s2, s3;
    s1 = pattern_state(8'h5A);
    s2 = pattern_state(8'h77);
    s3 = pattern_state(8'hEE);
    din = s1;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    for (int unsigned i = 0; i < 2*NBEATS; i++) begin
      n_checks++; if (doutix !== IX_W'(i % NBEATS)) begin n_fail++; $display("FAIL ovf_doutix[%0d]: got %0d required %0d", i, doutix, i % NBEATS); end
      n_checks++; if (dout !== beat_of(i < NBEATS ? s1 : s2, i % NBEATS)) begin
        n_fail++; $display("FAIL ovf_dout[%0d]: got %h required %h", i, dout, beat_of(i < NBEATS ? s1 : s2, i % NBEATS));
      end
      if (i == 2) begin
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b required 0", ready); end
      end
      if (i == 3) begin
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", overflow); end
      end
      if (i == 1) begin din = s2; pushin = 1'b1; end
      else if (i == 2) begin din = s3; pushin = 1'b1; end
      else pushin = 1'b0;
      step();
    end
    pushin = 1'b0;
    n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL ovf_end_pushout: got %b required 0", pushout); end
    for (int unsigned i = 0; i < 4; i++) step();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_reset_mid_stream();
    logic [STATE_W-1:0] s1, s2;
    s1 = pattern_state(8'h99);
    s2 = pattern_state(8'h42);
    din = s1;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    for (int unsigned i = 0; i < 4; i++) step();
    n_checks++; if (doutix !== IX_W'(4)) begin n_fail++; $display("FAIL mid_pre_doutix: got %0d required 4", doutix); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL mid_pushout: got %b required 0", pushout); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL mid_dout: got %h required 0", dout); end
    n_checks++; if (doutix !== '0) begin n_fail++; $display("FAIL mid_doutix: got %0d required 0", doutix); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b required 0", overflow); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b required 1", ready); end
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      n_checks++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL mid_quiet[%0d]: got %b required 0", i, pushout); end
    end
    din = s2;
    pushin = 1'b1;
    step();
    pushin = 1'b0;
    for (int unsigned k = 0; k < NBEATS; k++) begin
      n_checks++; if (doutix !== IX_W'(k)) begin n_fail++; $display("FAIL mid_post_doutix[%0d]: got %0d required %0d", k, doutix, k); end
      n_checks++; if (dout !== beat_of(s2, k)) begin n_fail++; $display("FAIL mid_post_dout[%0d]: got %h required %h", k, dout, beat_of(s2, k)); end
      step();
    end
  endtask

  task automatic test_random();
    logic [STATE_W-1:0] q[$];
    logic [STATE_W-1:0] asm_s, exp_s, s;
    logic [IX_W-1:0]    exp_ix;
    int unsigned        nstates;
    asm_s = '0;
    exp_ix = '0;
    nstates = 0;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if (pushout) begin
        n_checks++; if (doutix !== exp_ix) begin n_fail++; $display("FAIL rand_doutix @%0d: got %0d required %0d", cyc, doutix, exp_ix); end
        asm_s[int'(exp_ix)*BEAT_W +: BEAT_W] = dout;
        if (exp_ix == IX_W'(NBEATS - 1)) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++; $display("FAIL rand_extra_state @%0d: got unexpected state required none", cyc);
          end else begin
            exp_s = q.pop_front();
            if (asm_s !== exp_s) begin
              n_fail++; $display("FAIL rand_state #%0d: got low %h required low %h", nstates, asm_s[127:0], exp_s[127:0]);
            end
          end
          nstates++;
        end
        exp_ix = exp_ix + IX_W'(1);
      end else if (exp_ix != '0) begin
        n_checks++; n_fail++;
        $display("FAIL rand_gap @%0d: got pushout 0 mid-state required 1", cyc);
        exp_ix = '0;
      end
      if (cyc < 2950 && ready && ($urandom_range(0, 3) != 0)) begin
        s = rand_state();
        din = s;
        pushin = 1'b1;
        q.push_back(s);
      end else begin
        pushin = 1'b0;
      end
      step();
    end
    pushin = 1'b0;
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d states left required 0", q.size()); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow: got %b required 0", overflow); end
    n_checks++; if (nstates < 100) begin n_fail++; $display("FAIL rand_volume: got %0d states required at least 100", nstates); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_direct_reload();
    test_overflow();
    test_reset_mid_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
